padder_pipe: RTL and testbench
==============================

# padder_pipe

Parametrised, pipelined WIDTH-bit adder with carry-in/carry-out and a valid/ready handshake. The block generalises the single-cycle combinational full adder. The carry chain is split into SEGS registered segments so that wide sums close timing. One result is accepted per cycle, subject to backpressure. It sits between an operand producer and a result consumer in the datapath.

## Interface
- WIDTH, 32, operand/sum width in bits; must be a multiple of SEGS
- SEGS, 4, pipeline segments; segment width SW = WIDTH/SEGS; SEGS ≥ 1
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A, unsigned/two's complement
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (borrow-in when sub=1)
- sub  input  1  subtract select; exists only with PADDER_SUB_EN
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result bits
- c_out  output  1  carry-out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stall: `stall = out_valid && !out_ready`. Tie `in_ready = !stall`. When stall=1, every pipeline register, including per-stage valid bits, holds its value.
- Stage k (0..SEGS-1) adds segment k of a and b plus a carry:
  - Stage 0 uses c_in as its carry.
  - Stage k>0 uses the carry registered by stage k-1.
  - The stage registers its SW-bit partial sum and carry-out.
- Skew/deskew:
  - Operand segment k travels through k delay registers before its adder.
  - Partial sum k travels through SEGS-1-k registers after its adder.
  - All segments of one transaction therefore emerge together.
- Per-stage valid bit shifts with the data. Bubbles are allowed; no reordering; no squashing of bubbles while stalled.
- Arithmetic: `{c_out, sum} = a + b + c_in`, modulo 2^(WIDTH+1).
- ovf is computed in the final stage from the MSB segment's carry-in and carry-out.
- Data registers need no reset. Valid bits must be reset.
- Reset values: out_valid=0, in_ready=1, sum=0, c_out=0, ovf=0.
- Reset asserted mid-operation clears all in-flight transactions; nothing is emitted after release.
- While out_valid=0, sum/c_out/ovf hold their last value, or 0 after reset.

## Timing
- Latency: a transfer in at edge N produces out_valid=1 after edge N+SEGS, provided no stall occurs.
- Each stall cycle adds exactly one cycle of latency to every in-flight transaction.
- Throughput: 1 transaction/cycle while out_ready=1.
- SEGS=1 degenerates to a single registered adder with latency 1.
- in_ready depends combinationally on out_ready. This is the only comb path from input to output.
- Simultaneous in/out transfer in the same cycle with a full pipeline is legal and loses nothing.
- Critical path: one SW-bit adder plus carry mux.

## Configuration
- PADDER_SUB_EN defined:
  - The sub port exists.
  - sub=1 computes `a + ~b + ~c_in`, i.e. a − b − c_in.
  - c_out=1 means no borrow. ovf is the signed subtraction overflow.
  - sub is pipelined with its transaction: b inversion happens per segment at that segment's adder, and c_in inversion at stage 0.
- PADDER_SUB_EN undefined: no sub port; add only. Logic is identical to sub tied 0.

## Test plan
All scenarios use WIDTH=32, SEGS=4.
- Basic add and latency: a=255, b=89, c_in=0, one transfer at cycle 0 → out_valid at cycle 4 with sum=344, c_out=0, ovf=0.
- Full carry ripple across all segments: a=0xFFFFFFFF, b=0, c_in=1 → sum=0, c_out=1, ovf=0. Then a=0x7FFFFFFF, b=1 → sum=0x80000000, c_out=0, ovf=1.
- Streaming with backpressure:
  - Stimulus: 8 back-to-back transfers a=i, b=2i, c_in=i[0]; out_ready=0 for cycles 6–8.
  - Required response: in_ready=0 exactly during the stall; results 3i+i[0] in order; none lost or duplicated.
- Reset mid-flight: 3 transfers, assert rst asynchronously between edges 2 and 3 → out_valid drops immediately and stays 0. Post-release transfer a=1, b=0 → sum=1 after 4 cycles.
- Bubbles: in_valid alternating 1/0 with a=128, b=64, c_in=1 → out_valid alternating, each sum=193.
- Subtract (PADDER_SUB_EN): a=9, b=4, sub=1, c_in=0 → sum=5, c_out=1. Then a=4, b=9 → sum=0xFFFFFFFB, c_out=0, ovf=0.

Source files
------------

// File: rtl/padder_pipe.sv
// padder_pipe: WIDTH-bit adder, carry chain split into SEGS registered segments, valid/ready handshake.
// Define PADDER_SUB_EN to add the sub port (sub=1 computes a - b - c_in).
module padder_pipe #(
   parameter int WIDTH = 32,
   parameter int SEGS  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef PADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);
   localparam int SW = WIDTH / SEGS;
   logic sub_i;
`ifdef PADDER_SUB_EN
   assign sub_i = sub;
`else
   assign sub_i = 1'b0;
`endif
   logic             stall, ov_nx;
   logic [SEGS-1:0]  v, vin;
   logic [WIDTH-1:0] p_a [SEGS], p_b [SEGS], p_s [SEGS];
   logic             p_c [SEGS], p_sb [SEGS];
   logic [WIDTH-1:0] ai [SEGS], bi [SEGS], si [SEGS], sn [SEGS];
   logic [SW-1:0]    bx [SEGS], sg [SEGS];
   logic             ci [SEGS], co [SEGS], sb [SEGS];
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = v[SEGS-1];
   // Register k carries full-width operands and partial sum; unused segments fall away in synthesis.
   always_comb begin
      ai[0]  = a;
      bi[0]  = b;
      si[0]  = '0;
      ci[0]  = c_in ^ sub_i;
      sb[0]  = sub_i;
      vin[0] = in_valid;
      for (int k = 1; k < SEGS; k++) begin
         ai[k]  = p_a[k-1];
         bi[k]  = p_b[k-1];
         si[k]  = p_s[k-1];
         ci[k]  = p_c[k-1];
         sb[k]  = p_sb[k-1];
         vin[k] = v[k-1];
      end
      for (int k = 0; k < SEGS; k++) begin
         bx[k] = bi[k][k*SW +: SW] ^ {SW{sb[k]}};
         {co[k], sg[k]} = (SW+1)'(ai[k][k*SW +: SW]) + (SW+1)'(bx[k]) + (SW+1)'(ci[k]);
         sn[k] = si[k];
         sn[k][k*SW +: SW] = sg[k];
      end
      // carry into the MSB is recovered from the MSB's operand and sum bits
      ov_nx = co[SEGS-1] ^ ai[SEGS-1][WIDTH-1] ^ bx[SEGS-1][SW-1] ^ sg[SEGS-1][SW-1];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) v <= '0;
      else if (!stall) v <= vin;
   always_ff @(posedge clk)
      for (int k = 0; k < SEGS; k++)
         if (!stall && vin[k]) begin
            p_a[k]  <= ai[k];
            p_b[k]  <= bi[k];
            p_s[k]  <= sn[k];
            p_c[k]  <= co[k];
            p_sb[k] <= sb[k];
         end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sum   <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
      end else if (!stall && vin[SEGS-1]) begin
         sum   <= sn[SEGS-1];
         c_out <= co[SEGS-1];
         ovf   <= ov_nx;
      end
endmodule

// File: tb/tb_padder_pipe.sv
// tb_padder_pipe: directed and random stimulus against an integer-arithmetic reference with an in-order scoreboard.
module tb_padder_pipe;
   localparam int W = 32;
   localparam int S = 4;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, c_in = 1'b0, sub = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, c_out, ovf;
   logic [W-1:0] a = '0, b = '0, sum;
   logic seen_v, seen_r;
   int n_cmp = 0, n_err = 0, n_pop = 0;
   logic [33:0] q[$];

   padder_pipe #(.WIDTH(W), .SEGS(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in),
`ifdef PADDER_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {ovf, c_out, sum} from signed/unsigned integer arithmetic
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
      longint r, u;
      logic cy;
      if (s) begin
         r  = longint'(signed'(x)) - longint'(signed'(y)) - longint'(c);
         u  = longint'(x) - longint'(y) - longint'(c);
         cy = longint'(x) >= longint'(y) + longint'(c);
      end else begin
         r  = longint'(signed'(x)) + longint'(signed'(y)) + longint'(c);
         u  = longint'(x) + longint'(y) + longint'(c);
         cy = u > 64'sd4294967295;
      end
      return {(r > 64'sd2147483647) || (r < -64'sd2147483648), cy, u[31:0]};
   endfunction

   task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ic, input logic is, input logic ordy);
      in_valid = iv; a = ia; b = ib; c_in = ic; sub = is; out_ready = ordy;
      #1;
      seen_v = out_valid;
      seen_r = in_ready;
      if (out_valid && out_ready) begin
         if (q.size() == 0) chk("spurious_out", out_valid, 0);
         else begin
            chk("result", {ovf, c_out, sum}, q.pop_front());
            n_pop++;
         end
      end
      if (in_valid && in_ready) q.push_back(model(ia, ib, ic, is));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int p0, cyc, i;
      logic rs;
      @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_sum", sum, 0);
      chk("rst_c_out", c_out, 0);
      chk("rst_ovf", ovf, 0);
      rst = 1'b0;
      // basic add and latency
      step(1'b1, 255, 89, 1'b0, 1'b0, 1'b1);
      for (int m = 1; m <= 5; m++) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         chk("latency_valid", seen_v, m == 4);
      end
      // full carry ripple and signed overflow
      step(1'b1, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h7FFF_FFFF, 1, 1'b0, 1'b0, 1'b1);
      idle(6);
      chk("ripple_drained", q.size(), 0);
      // streaming with backpressure in cycles 6..8
      p0 = n_pop;
      cyc = 0;
      i = 0;
      while (i < 8 && cyc < 30) begin
         step(1'b1, 32'(i), 32'(2 * i), i[0], 1'b0, !(cyc >= 6 && cyc <= 8));
         chk("stream_in_ready", seen_r, !(cyc >= 6 && cyc <= 8));
         if (seen_r) i++;
         cyc++;
      end
      idle(8);
      chk("stream_count", n_pop - p0, 8);
      chk("stream_drained", q.size(), 0);
      // bubbles
      for (int m = 0; m < 16; m++) begin
         step(m < 10 && m % 2 == 0, 128, 64, 1'b1, 1'b0, 1'b1);
         if (m >= 4) chk("bubble_valid", seen_v, (m - 4 < 10) && ((m - 4) % 2 == 0));
      end
      idle(4);
`ifdef PADDER_SUB_EN
      step(1'b1, 9, 4, 1'b0, 1'b1, 1'b1);
      step(1'b1, 4, 9, 1'b0, 1'b1, 1'b1);
      idle(6);
      chk("sub_drained", q.size(), 0);
`endif
      // random traffic
      for (int m = 0; m < 300; m++) begin
`ifdef PADDER_SUB_EN
         rs = 1'($urandom % 2);
`else
         rs = 1'b0;
`endif
         step($urandom % 4 != 0, $urandom, $urandom, 1'($urandom % 2), rs, $urandom % 4 != 0);
      end
      idle(10);
      chk("random_drained", q.size(), 0);
      // asynchronous reset with a result waiting at the output
      for (int m = 0; m < 3; m++) step(1'b1, 32'(m + 5), 7, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_in_ready", in_ready, 1);
      chk("async_rst_sum", sum, 0);
      q.delete();
      @(posedge clk);
      #3;
      rst = 1'b0;
      p0 = n_pop;
      for (int m = 0; m < 8; m++) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         chk("post_rst_quiet", seen_v, 0);
      end
      step(1'b1, 1, 0, 1'b0, 1'b0, 1'b1);
      idle(6);
      chk("post_rst_count", n_pop - p0, 1);
      chk("post_rst_sum", sum, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
